mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter between the instruction cache (`if_cache`) and the data cache (`mem_cache`) on one side and the single-ported memory simulator (`mem_sim`) on the other. It serialises cache refills and write-throughs, latches the granted request, and routes the 64-bit reply to the correct cache. The caches can then be connected to a memory model that serves exactly one transaction at a time.

## Interface
Parameters: none.

Clocking: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.

- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req_i`  in  1  instruction-cache request; level, held until `if_rep_o`
- `if_addr_i`  in  32  instruction-cache byte address
- `if_rep_o`  out  1  one-cycle reply pulse to instruction cache
- `if_rep_data_o`  out  64  refill data; valid while `if_rep_o`=1
- `mem_req_i`  in  1  data-cache request; level, held until `mem_rep_o`
- `mem_addr_i`  in  32  data-cache byte address
- `mem_write_i`  in  1  1 = write transaction, 0 = read refill
- `mem_write_data_i`  in  32  write data
- `mem_write_mask_i`  in  4  byte enables, bit i = byte i
- `mem_rep_o`  out  1  one-cycle reply pulse to data cache
- `mem_rep_data_o`  out  64  refill data; valid while `mem_rep_o`=1
- `ms_req_o`  out  1  request to memory; level, held until `ms_rep_i`
- `ms_addr_o`  out  32  latched, aligned address
- `ms_write_o`  out  1  latched write flag
- `ms_write_data_o`  out  32  latched write data
- `ms_write_mask_o`  out  4  latched byte mask
- `ms_rep_i`  in  1  one-cycle completion pulse from memory
- `ms_rep_data_i`  in  64  memory read data; valid with `ms_rep_i`

## Operation
States: IDLE, BUSY, DONE.

- **IDLE**
  - Neither request pending: stay in IDLE.
  - Exactly one request pending: grant it.
  - Both pending: grant the port not served last. `last_grant` resets to IF, so the data cache wins the first tie.
  - On grant: latch the owner and the request fields into the `ms_*` registers; go to BUSY.
- **BUSY**
  - `ms_req_o`=1; all `ms_*` outputs stay stable.
  - On `ms_rep_i`=1: register `ms_rep_data_i` into the owner's `*_rep_data_o`; pulse the owner's `*_rep_o` next cycle; update `last_grant`; go to DONE.
- **DONE**
  - Lasts one cycle. The owner's `*_rep_o`=1; `ms_req_o`=0.
  - Always go to IDLE next. No grant is issued from DONE.
- Requester contract: a cache drops its `*_req_i` at the edge where it samples `*_rep_o`=1. Because DONE always inserts one IDLE cycle, the served request is never re-granted.
- Address alignment:
  - IF reads and `mem` reads: `ms_addr_o` = {addr[31:3], 3'b000}.
  - `mem` writes: `ms_addr_o` = {addr[31:2], 2'b00}.
  - `ms_write_o`, `ms_write_data_o` and `ms_write_mask_o` are forced to 0 for IF grants.
- Writes: `mem_rep_o` acknowledges completion. `mem_rep_data_o` still captures `ms_rep_data_i`; the cache treats it as don't-care.
- `ms_rep_i` in IDLE or DONE is spurious: ignore it, with no output change.
- Request inputs are sampled only in IDLE. Changes to `*_req_i` or the request fields while the block is in BUSY have no effect.
- `*_rep_data_o` holds its last value outside reply cycles.

## Timing
- Reset: state=IDLE, `last_grant`=IF. `if_rep_o`=0, `mem_rep_o`=0, `ms_req_o`=0, `ms_write_o`=0. `ms_addr_o`, `ms_write_data_o`, `ms_write_mask_o`, `if_rep_data_o` and `mem_rep_data_o` are all 0.
- Latency (request cycle = 0):
  - Request seen in IDLE at cycle 0: `ms_req_o`=1 from cycle 1.
  - `ms_rep_i` at cycle k (k≥1): `*_rep_o`=1 with data at cycle k+1.
  - IDLE at cycle k+2; the next grant is visible at cycle k+3.
- Zero-wait memory (`ms_rep_i` in cycle 1): reply at cycle 2; back-to-back transactions every 3 cycles.
- `rst` mid-transaction: abort the transaction, with no reply pulse. All outputs take reset values at the next edge. The memory model is reset in the same cycle.
- At most one `*_rep_o` is high in any cycle. `if_rep_o` and `mem_rep_o` are never high together.

## Test plan
- **Single IF read:** `if_req_i`=1, `if_addr_i`=0x0000_0104; memory replies after 3 cycles with 0x1122334455667788.
  - Expect `ms_addr_o`=0x0000_0100 and `ms_write_o`=0.
  - Expect `if_rep_o` pulse one cycle after `ms_rep_i`, with `if_rep_data_o`=0x1122334455667788.
  - Expect `mem_rep_o`=0 throughout.
- **Data write:** `mem_addr_i`=0x0000_2006, `mem_write_i`=1, data 0xDEADBEEF, mask 4'b1100.
  - Expect `ms_addr_o`=0x0000_2004, `ms_write_o`=1, `ms_write_data_o`=0xDEADBEEF, `ms_write_mask_o`=4'b1100.
  - Expect a single `mem_rep_o` pulse.
- **Simultaneous requests after reset:** first grant goes to `mem`. With both requests held, the IF grant follows with exactly one IDLE cycle between the two transactions.
- **Fairness:** both requesters re-request immediately after every reply for 6 transactions. Expect grants to strictly alternate mem, IF, mem, IF, mem, IF.
- **Spurious reply:** `ms_rep_i` pulsed in IDLE and in DONE. Expect no `*_rep_o` pulse and unchanged data outputs.
- **Reset mid-transaction:** assert `rst` in BUSY, then deassert. Expect all outputs at reset values, no reply pulse, and a correct new transaction afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter that lets the instruction cache and the data cache share one
// single-ported memory, one transaction at a time, with round-robin tie breaking.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rep_o,
  output logic [63:0] if_rep_data_o,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_write_data_i,
  input  logic [3:0]  mem_write_mask_i,
  output logic        mem_rep_o,
  output logic [63:0] mem_rep_data_o,
  output logic        ms_req_o,
  output logic [31:0] ms_addr_o,
  output logic        ms_write_o,
  output logic [31:0] ms_write_data_o,
  output logic [3:0]  ms_write_mask_o,
  input  logic        ms_rep_i,
  input  logic [63:0] ms_rep_data_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;

  state_t state, state_nxt;
  owner_t owner, last_grant, grant_sel;
  logic   grant_vld;

  // When both caches ask, the one that was not served last wins.
  always_comb begin
    grant_vld = if_req_i | mem_req_i;
    grant_sel = OWN_IF;
    if (if_req_i && mem_req_i)
      grant_sel = (last_grant == OWN_IF) ? OWN_MEM : OWN_IF;
    else if (mem_req_i)
      grant_sel = OWN_MEM;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = BUSY;
      BUSY:    if (ms_rep_i)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and reply capture; all of it is cleared so the memory side sees zeros after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner           <= OWN_IF;
      last_grant      <= OWN_IF;
      ms_addr_o       <= '0;
      ms_write_o      <= 1'b0;
      ms_write_data_o <= '0;
      ms_write_mask_o <= '0;
      if_rep_data_o   <= '0;
      mem_rep_data_o  <= '0;
    end else begin
      if (state == IDLE && grant_vld) begin
        owner <= grant_sel;
        if (grant_sel == OWN_MEM) begin
          // Writes are word aligned, refills are doubleword aligned.
          ms_addr_o       <= mem_addr_i & (mem_write_i ? 32'hFFFF_FFFC : 32'hFFFF_FFF8);
          ms_write_o      <= mem_write_i;
          ms_write_data_o <= mem_write_data_i;
          ms_write_mask_o <= mem_write_mask_i;
        end else begin
          ms_addr_o       <= if_addr_i & 32'hFFFF_FFF8;
          ms_write_o      <= 1'b0;
          ms_write_data_o <= '0;
          ms_write_mask_o <= '0;
        end
      end
      if (state == BUSY && ms_rep_i) begin
        last_grant <= owner;
        if (owner == OWN_MEM) mem_rep_data_o <= ms_rep_data_i;
        else                  if_rep_data_o  <= ms_rep_data_i;
      end
    end
  end

  always_comb begin
    ms_req_o  = (state == BUSY);
    if_rep_o  = (state == DONE) && (owner == OWN_IF);
    mem_rep_o = (state == DONE) && (owner == OWN_MEM);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_rep_o;
  logic [63:0] if_rep_data_o;
  logic        mem_req_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic        mem_write_i = 1'b0;
  logic [31:0] mem_write_data_i = '0;
  logic [3:0]  mem_write_mask_i = '0;
  logic        mem_rep_o;
  logic [63:0] mem_rep_data_o;
  logic        ms_req_o;
  logic [31:0] ms_addr_o;
  logic        ms_write_o;
  logic [31:0] ms_write_data_o;
  logic [3:0]  ms_write_mask_o;
  logic        ms_rep_i = 1'b0;
  logic [63:0] ms_rep_data_i = '0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rep_o(if_rep_o), .if_rep_data_o(if_rep_data_o),
    .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_write_i(mem_write_i),
    .mem_write_data_i(mem_write_data_i), .mem_write_mask_i(mem_write_mask_i),
    .mem_rep_o(mem_rep_o), .mem_rep_data_o(mem_rep_data_o),
    .ms_req_o(ms_req_o), .ms_addr_o(ms_addr_o), .ms_write_o(ms_write_o),
    .ms_write_data_o(ms_write_data_o), .ms_write_mask_o(ms_write_mask_o),
    .ms_rep_i(ms_rep_i), .ms_rep_data_i(ms_rep_data_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum {P_IF, P_MEM} port_e;

  bit          m_busy = 0;     // a transaction is in flight at the memory
  bit          m_done = 0;     // the reply cycle towards the owner
  port_e       m_owner = P_IF;
  port_e       m_last = P_IF;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_mask = '0;
  logic        m_write = 1'b0;
  logic [63:0] m_if_data = '0, m_mem_data = '0;

  function automatic port_e pick(bit want_if, bit want_mem, port_e last);
    if (want_if && want_mem) return (last == P_IF) ? P_MEM : P_IF;
    return want_mem ? P_MEM : P_IF;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_last <= P_IF;
      m_addr <= '0; m_wdata <= '0; m_mask <= '0; m_write <= 1'b0;
      m_if_data <= '0; m_mem_data <= '0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      if (ms_rep_i) begin
        m_busy <= 0;
        m_done <= 1;
        m_last <= m_owner;
        if (m_owner == P_IF) m_if_data  <= ms_rep_data_i;
        else                 m_mem_data <= ms_rep_data_i;
      end
    end else if (if_req_i || mem_req_i) begin
      m_busy  <= 1;
      m_owner <= pick(if_req_i, mem_req_i, m_last);
      if (pick(if_req_i, mem_req_i, m_last) == P_IF) begin
        m_addr <= if_addr_i - (if_addr_i % 8);
        m_write <= 1'b0; m_wdata <= '0; m_mask <= '0;
      end else begin
        m_addr  <= mem_write_i ? mem_addr_i - (mem_addr_i % 4) : mem_addr_i - (mem_addr_i % 8);
        m_write <= mem_write_i; m_wdata <= mem_write_data_i; m_mask <= mem_write_mask_i;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("ms_req", 64'(ms_req_o), 64'(m_busy));
      check("if_rep", 64'(if_rep_o), 64'(m_done && m_owner == P_IF));
      check("mem_rep", 64'(mem_rep_o), 64'(m_done && m_owner == P_MEM));
      check("if_rep_data", if_rep_data_o, m_if_data);
      check("mem_rep_data", mem_rep_data_o, m_mem_data);
      check("ms_addr", 64'(ms_addr_o), 64'(m_addr));
      check("ms_write", 64'(ms_write_o), 64'(m_write));
      check("ms_wdata", 64'(ms_write_data_o), 64'(m_wdata));
      check("ms_mask", 64'(ms_write_mask_o), 64'(m_mask));
      check("rep_exclusive", 64'(if_rep_o & mem_rep_o), 64'd0);
    end
  end

  // ---------------- memory model and requesters, all stepped from tick() ----------------
  int          cyc = 0, rep_cyc = -10;
  int          if_rep_cnt = 0, mem_rep_cnt = 0;
  bit          rand_mode = 0, rand_req = 0;
  int          mem_lat = 0, mem_wait = 0;
  bit          mem_active = 0;
  logic [63:0] fixed_data = '0;

  task automatic drive_random();
    if (if_req_i) begin
      if (if_rep_o) if_req_i = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      if_req_i = 1'b1; if_addr_i = $urandom;
    end
    if (mem_req_i) begin
      if (mem_rep_o) mem_req_i = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      mem_req_i = 1'b1; mem_addr_i = $urandom; mem_write_i = 1'($urandom_range(0, 1));
      mem_write_data_i = $urandom; mem_write_mask_i = 4'($urandom);
    end
    // Field changes while the memory is busy must not reach the latched request.
    if (ms_req_o && $urandom_range(0, 3) == 0) begin
      if_addr_i = $urandom; mem_addr_i = $urandom; mem_write_i = 1'($urandom_range(0, 1));
      mem_write_data_i = $urandom; mem_write_mask_i = 4'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (if_rep_o)  if_rep_cnt++;
    if (mem_rep_o) mem_rep_cnt++;
    ms_rep_i = 1'b0;
    if (rst) begin
      mem_active = 0;
    end else if (ms_req_o) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_wait = rand_mode ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (mem_wait == 0) begin
        ms_rep_i = 1'b1;
        ms_rep_data_i = rand_mode ? {$urandom, $urandom} : fixed_data;
        mem_active = 0;
        rep_cyc = cyc;
      end else begin
        mem_wait--;
      end
    end else if (rand_mode && $urandom_range(0, 4) == 0) begin
      ms_rep_i = 1'b1;
      ms_rep_data_i = {$urandom, $urandom};
    end
    if (rand_req) drive_random();
  endtask

  task automatic wait_rep(input bit want_mem, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (want_mem ? mem_rep_o : if_rep_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    bit ok;
    int c0, c1, n;
    logic [7:0] got;
    logic [5:0] exp_order;

    tick();
    chk_en = 1;
    check("rst_ms_req", 64'(ms_req_o), 64'd0);
    check("rst_if_rep", 64'(if_rep_o), 64'd0);
    check("rst_mem_rep", 64'(mem_rep_o), 64'd0);
    check("rst_ms_addr", 64'(ms_addr_o), 64'd0);
    check("rst_ms_write", 64'(ms_write_o), 64'd0);
    check("rst_if_data", if_rep_data_o, 64'd0);
    check("rst_mem_data", mem_rep_data_o, 64'd0);
    rst = 1'b0;
    tick();

    // Single IF read with a 3-cycle memory.
    mem_lat = 2; fixed_data = 64'h1122334455667788;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0104;
    c0 = mem_rep_cnt;
    tick();
    check("ifrd_ms_req", 64'(ms_req_o), 64'd1);
    check("ifrd_ms_addr", 64'(ms_addr_o), 64'h0000_0100);
    check("ifrd_ms_write", 64'(ms_write_o), 64'd0);
    wait_rep(0, 20, ok);
    check("ifrd_reply_seen", 64'(ok), 64'd1);
    check("ifrd_reply_lat", 64'(cyc), 64'(rep_cyc + 1));
    check("ifrd_data", if_rep_data_o, 64'h1122334455667788);
    if_req_i = 1'b0;

    // Spurious replies in DONE and then in IDLE.
    ms_rep_i = 1'b1; ms_rep_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    check("spur_done_if_rep", 64'(if_rep_o), 64'd0);
    check("spur_done_mem_rep", 64'(mem_rep_o), 64'd0);
    check("spur_done_data", if_rep_data_o, 64'h1122334455667788);
    ms_rep_i = 1'b1; ms_rep_data_i = 64'hFACE_FACE_FACE_FACE;
    tick();
    tick();
    check("spur_idle_ms_req", 64'(ms_req_o), 64'd0);
    check("spur_idle_data", if_rep_data_o, 64'h1122334455667788);
    check("spur_idle_mem_data", mem_rep_data_o, 64'd0);
    check("ifrd_no_mem_rep", 64'(mem_rep_cnt - c0), 64'd0);
    check("spur_no_if_rep", 64'(if_rep_cnt), 64'd1);

    // Data write, with request fields scrambled while the memory is busy.
    mem_lat = 1; fixed_data = 64'h0123_4567_89AB_CDEF;
    mem_req_i = 1'b1; mem_addr_i = 32'h0000_2006; mem_write_i = 1'b1;
    mem_write_data_i = 32'hDEAD_BEEF; mem_write_mask_i = 4'b1100;
    c0 = mem_rep_cnt;
    tick();
    check("wr_ms_addr", 64'(ms_addr_o), 64'h0000_2004);
    check("wr_ms_write", 64'(ms_write_o), 64'd1);
    check("wr_ms_wdata", 64'(ms_write_data_o), 64'hDEAD_BEEF);
    check("wr_ms_mask", 64'(ms_write_mask_o), 64'b1100);
    mem_addr_i = 32'hFFFF_FFF0; mem_write_data_i = 32'h5555_5555; mem_write_mask_i = 4'b0011;
    tick();
    check("wr_hold_addr", 64'(ms_addr_o), 64'h0000_2004);
    check("wr_hold_wdata", 64'(ms_write_data_o), 64'hDEAD_BEEF);
    wait_rep(1, 20, ok);
    check("wr_reply_seen", 64'(ok), 64'd1);
    mem_req_i = 1'b0; mem_write_i = 1'b0;
    tick(); tick();
    check("wr_single_pulse", 64'(mem_rep_cnt - c0), 64'd1);

    // Simultaneous requests right after reset: mem first, one IDLE gap, then IF.
    reset_pulse();
    mem_lat = 0; fixed_data = 64'hA5A5_0000_5A5A_FFFF;
    if_req_i = 1'b1; if_addr_i = 32'h0000_301D;
    mem_req_i = 1'b1; mem_addr_i = 32'h0000_4ABC; mem_write_i = 1'b0;
    tick();
    check("sim_first_addr", 64'(ms_addr_o), 64'h0000_4AB8);
    tick();
    check("sim_first_mem_rep", 64'(mem_rep_o), 64'd1);
    check("sim_first_if_rep", 64'(if_rep_o), 64'd0);
    mem_req_i = 1'b0;
    tick();
    check("sim_gap", 64'(ms_req_o), 64'd0);
    tick();
    check("sim_second_req", 64'(ms_req_o), 64'd1);
    check("sim_second_addr", 64'(ms_addr_o), 64'h0000_3018);
    tick();
    check("sim_second_if_rep", 64'(if_rep_o), 64'd1);
    if_req_i = 1'b0;
    tick();

    // Fairness: both caches re-request after every reply.
    reset_pulse();
    mem_lat = 1;
    exp_order = 6'b010101;  // bit i = 1 when transaction i belongs to mem
    got = '0; n = 0;
    if_req_i = 1'b1; mem_req_i = 1'b1; if_addr_i = 32'h0000_1000; mem_addr_i = 32'h0000_8000;
    for (int i = 0; i < 80 && n < 6; i++) begin
      tick();
      if_req_i = 1'b1; mem_req_i = 1'b1;
      if (mem_rep_o) begin got[n] = 1'b1; n++; mem_req_i = 1'b0; end
      if (if_rep_o)  begin got[n] = 1'b0; n++; if_req_i  = 1'b0; end
    end
    check("fair_count", 64'(n), 64'd6);
    for (int i = 0; i < 6; i++) check("fair_order", 64'(got[i]), 64'(exp_order[i]));
    if_req_i = 1'b0; mem_req_i = 1'b0;

    // Reset in the middle of a transaction.
    reset_pulse();
    tick();
    mem_lat = 6; fixed_data = 64'h7777_7777_7777_7777;
    if_req_i = 1'b1; if_addr_i = 32'h0000_5555;
    tick(); tick();
    check("rstmid_busy", 64'(ms_req_o), 64'd1);
    rst = 1'b1; if_req_i = 1'b0;
    c1 = if_rep_cnt + mem_rep_cnt;
    tick();
    check("rstmid_ms_req", 64'(ms_req_o), 64'd0);
    check("rstmid_ms_addr", 64'(ms_addr_o), 64'd0);
    check("rstmid_if_data", if_rep_data_o, 64'd0);
    check("rstmid_mem_data", mem_rep_data_o, 64'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("rstmid_no_reply", 64'(if_rep_cnt + mem_rep_cnt - c1), 64'd0);
    mem_lat = 1; fixed_data = 64'hCAFE_F00D_1234_5678;
    mem_req_i = 1'b1; mem_addr_i = 32'h0000_7777; mem_write_i = 1'b0;
    tick();
    check("rstmid_new_addr", 64'(ms_addr_o), 64'h0000_7770);
    wait_rep(1, 20, ok);
    check("rstmid_new_reply", 64'(ok), 64'd1);
    check("rstmid_new_data", mem_rep_data_o, 64'hCAFE_F00D_1234_5678);
    mem_req_i = 1'b0;
    tick();

    // Random traffic, random latency and spurious replies, checked by the model every cycle.
    reset_pulse();
    c0 = if_rep_cnt + mem_rep_cnt;
    rand_mode = 1; rand_req = 1;
    repeat (3000) tick();
    rand_req = 0;
    if_req_i = 1'b0; mem_req_i = 1'b0;
    repeat (10) tick();
    check("rand_progress", 64'(if_rep_cnt + mem_rep_cnt - c0 > 200), 64'd1);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
